sevenseg_scan_to_bcd_reader: RTL and testbench

//  Receive end of the multiplexed 7-segment display interface: snoops the segment bus and
//  one-hot digit strobes driven to a display, and recovers each digit as BCD plus decimal point.

---
 rtl/sevenseg_scan_to_bcd_reader.sv | 168 ++++++++++++++++
 tb/tb_sevenseg_scan_to_bcd_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_to_bcd_reader.sv
// Recovers BCD digits + dp from a snooped multiplexed 7-segment bus.
// Define SYNC_INPUTS_EN to add a 2-flop synchroniser on all inputs.
module sevenseg_scan_to_bcd_reader #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_sel,
   input  logic                  ca_mode,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     dp_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic [DIGITS-1:0]     err_out,
   output logic                  frame_valid
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

   logic [7:0]        seg_s;
   logic [DIGITS-1:0] sel_s;
   logic              ca_s;

`ifdef SYNC_INPUTS_EN
   logic [7:0]        seg_m;
   logic [DIGITS-1:0] sel_m;
   logic              ca_m;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_m <= '0;
         sel_m <= '0;
         ca_m  <= 1'b0;
         seg_s <= '0;
         sel_s <= '0;
         ca_s  <= 1'b0;
      end else begin
         seg_m <= seg_in;
         sel_m <= dig_sel;
         ca_m  <= ca_mode;
         seg_s <= seg_m;
         sel_s <= sel_m;
         ca_s  <= ca_m;
      end
   end
`else
   assign seg_s = seg_in;
   assign sel_s = dig_sel;
   assign ca_s  = ca_mode;
`endif

   // {err, bcd}; dp bit is not part of the glyph
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h7E:   decode = 5'h00;
         7'h30:   decode = 5'h01;
         7'h6D:   decode = 5'h02;
         7'h79:   decode = 5'h03;
         7'h33:   decode = 5'h04;
         7'h5B:   decode = 5'h05;
         7'h5F:   decode = 5'h06;
         7'h70:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h7B:   decode = 5'h09;
         default: decode = 5'h1F;
      endcase
   endfunction

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [DIGITS-1:0] sel_q, sel_n;
   logic [7:0]        pat_q, pat_n;
   logic [7:0]        pat;
   logic [4:0]        dec;
   logic              latch;
   logic              oh;
   logic [DIGITS-1:0] seen, seen_n;
   logic              full;

   assign pat = ca_s ? ~seg_s : seg_s;
   assign dec = decode(pat[7:1]);
   assign oh  = $onehot(sel_s);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sel_n   = sel_q;
      pat_n   = pat_q;
      latch   = 1'b0;
      case (state)
         IDLE: begin
            if (oh) begin
               sel_n   = sel_s;
               pat_n   = pat;
               cnt_n   = ONE;
               state_n = TRACK;
            end
         end
         TRACK, HOLD: begin
            if (!oh) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (sel_s != sel_q || pat != pat_q) begin
               sel_n   = sel_s;
               pat_n   = pat;
               cnt_n   = ONE;
               state_n = TRACK;
            end else if (state == TRACK) begin
               cnt_n = (cnt == CMAX) ? CMAX : cnt + ONE;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = IDLE;
         end
      endcase
      // any entry into TRACK that reaches the threshold latches now
      if (state_n == TRACK && cnt_n == CMAX) begin
         latch   = 1'b1;
         state_n = HOLD;
      end
   end

   assign seen_n = seen | (latch ? sel_n : '0);
   assign full   = &seen_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         sel_q <= '0;
         pat_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         sel_q <= sel_n;
         pat_q <= pat_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_out     <= '0;
         dp_out      <= '0;
         digit_valid <= '0;
         err_out     <= '0;
         seen        <= '0;
         frame_valid <= 1'b0;
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (latch && sel_n[i]) begin
               bcd_out[4*i +: 4] <= dec[3:0];
               dp_out[i]         <= pat[0];
               err_out[i]        <= dec[4];
               digit_valid[i]    <= 1'b1;
            end
         end
         frame_valid <= full;
         seen        <= full ? '0 : seen_n;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_to_bcd_reader.sv
// Scoreboard bench: stimulus queues expected snapshots, a monitor
// compares them whenever the reader's outputs change or frame pulses.
module tb_sevenseg_scan_to_bcd_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  seg_in = 8'h00;
   logic [3:0]  dig_sel = 4'b0000;
   logic        ca_mode = 1'b0;
   logic [15:0] bcd_out;
   logic [3:0]  dp_out;
   logic [3:0]  digit_valid;
   logic [3:0]  err_out;
   logic        frame_valid;

   sevenseg_scan_to_bcd_reader #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
      .clk(clk),
      .rst(rst),
      .seg_in(seg_in),
      .dig_sel(dig_sel),
      .ca_mode(ca_mode),
      .bcd_out(bcd_out),
      .dp_out(dp_out),
      .digit_valid(digit_valid),
      .err_out(err_out),
      .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  dp;
      logic [3:0]  vld;
      logic [3:0]  err;
      logic        frm;
   } snap_t;

   snap_t q[$];
   snap_t m = '0;
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // hold inputs for n sampling edges, return just after the next negedge
   task automatic drive(input logic [3:0] s, input logic [7:0] g,
                        input logic c, input int n);
      dig_sel = s;
      seg_in  = g;
      ca_mode = c;
      repeat (n) @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic expect_latch(input int i, input logic [3:0] b,
                               input logic d, input logic e,
                               input logic f);
      m.bcd[4*i +: 4] = b;
      m.dp[i]  = d;
      m.err[i] = e;
      m.vld[i] = 1'b1;
      m.frm    = f;
      q.push_back(m);
      m.frm = 1'b0;
   endtask

   initial begin : monitor
      snap_t prev;
      snap_t cur;
      snap_t e;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {bcd_out, dp_out, digit_valid, err_out, frame_valid};
         if (!rst && (frame_valid ||
             cur[28:1] != prev[28:1])) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_update: got %h expected no change",
                        cur);
            end else begin
               e = q.pop_front();
               chk("bcd_out", cur.bcd, e.bcd);
               chk("dp_out", {12'h0, cur.dp}, {12'h0, e.dp});
               chk("digit_valid", {12'h0, cur.vld}, {12'h0, e.vld});
               chk("err_out", {12'h0, cur.err}, {12'h0, e.err});
               chk("frame_valid", {15'h0, cur.frm}, {15'h0, e.frm});
            end
         end
         prev = cur;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      dig_sel = 4'b0001;
      seg_in  = 8'hDA;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_state",
          {bcd_out[11:0], dp_out},
          16'h0000);
      chk("reset_flags",
          {8'h0, digit_valid, err_out},
          {7'h0, frame_valid, 8'h00});

      // 1: reset in the middle of a capture
      rst = 1'b0;
      drive(4'b0001, 8'hDA, 1'b0, 2);
      rst = 1'b1;
      #1;
      chk("midscan_reset", bcd_out, 16'h0000);
      @(negedge clk);
      #1;
      rst = 1'b0;
      expect_latch(0, 4'h2, 1'b0, 1'b0, 1'b0);
      drive(4'b0001, 8'hDA, 1'b0, 2);
      chk("no_early_latch_rst", 16'(q.size()), 16'd1);
      // 2: CC digit 0 = 2
      drive(4'b0001, 8'hDA, 1'b0, 1);

      // 3: CA digit 2 = 5 with dp
      expect_latch(2, 4'h5, 1'b1, 1'b0, 1'b0);
      drive(4'b0100, 8'h48, 1'b1, 3);

      // 4: illegal pattern on digit 1
      expect_latch(1, 4'hF, 1'b0, 1'b1, 1'b0);
      drive(4'b0010, 8'h02, 1'b0, 3);

      // 5: glitch on digit 3, completes the first frame
      drive(4'b1000, 8'h60, 1'b0, 2);
      chk("no_latch_glitch", 16'(q.size()), 16'd0);
      expect_latch(3, 4'h3, 1'b0, 1'b0, 1'b1);
      drive(4'b1000, 8'hF2, 1'b0, 3);
      drive(4'b0011, 8'hF2, 1'b0, 5);
      chk("multihot_hold", bcd_out, m.bcd);
      drive(4'b0000, 8'h00, 1'b0, 1);

      // 6: full scan 1,9,0,7
      expect_latch(0, 4'h1, 1'b0, 1'b0, 1'b0);
      drive(4'b0001, 8'h60, 1'b0, 3);
      expect_latch(1, 4'h9, 1'b0, 1'b0, 1'b0);
      drive(4'b0010, 8'hF6, 1'b0, 3);
      expect_latch(2, 4'h0, 1'b0, 1'b0, 1'b0);
      drive(4'b0100, 8'hFC, 1'b0, 3);
      expect_latch(3, 4'h7, 1'b0, 1'b0, 1'b1);
      drive(4'b1000, 8'hE0, 1'b0, 3);
      drive(4'b1000, 8'hE0, 1'b0, 3);
      chk("scan_result", bcd_out, 16'h7091);

      drive(4'b0000, 8'h00, 1'b0, 3);
      chk("queue_drained", 16'(q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
